// File: rtl/note_output_arbiter.sv
//============================================================================
// Module      : note_output_arbiter
// Description : Shares the piano note/octave/LED output path between the
//               free, auto and learn sources. It selects a source from the
//               one-hot mode switches, inserts a muted gap of GAP_CYCLES
//               after every mode change, and owns the auto-playback
//               run/pause state, which rising start edges toggle.
//               Optional feature macro: KEY_OVERRIDE_EN. When it is
//               defined, a nonzero free key preempts auto playback.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module note_output_arbiter #(
    parameter int GAP_CYCLES = 100000,
    parameter int CNT_W      = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] mode,
    input  logic       start,
    input  logic [3:0] note_free,
    input  logic [3:0] note_auto,
    input  logic [3:0] note_learn,
    input  logic [1:0] octave_free,
    input  logic [1:0] octave_auto,
    input  logic [1:0] octave_learn,
    input  logic [6:0] led_free,
    input  logic [6:0] led_auto,
    input  logic [6:0] led_learn,
    output logic [3:0] note_out,
    output logic [1:0] octave_out,
    output logic [6:0] led_out,
    output logic       play_state,
    output logic       muting,
    output logic [1:0] grant
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SWITCH = 2'd1;
    localparam logic [1:0] c_ST_ACTIVE = 2'd2;

    localparam logic [2:0] c_MODE_FREE  = 3'b100;
    localparam logic [2:0] c_MODE_AUTO  = 3'b010;
    localparam logic [2:0] c_MODE_LEARN = 3'b001;

    localparam logic [CNT_W-1:0] c_GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_mode_q;
    logic             r_start_d;
    logic             r_play_state;
    logic [3:0]       r_note;
    logic [1:0]       r_octave;
    logic [6:0]       r_led;
    logic             r_muting;
    logic [1:0]       r_grant;

    logic             w_mode_valid;
    logic             w_mode_chg;
    logic             w_start_rise;
    logic             w_pass;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_play_nxt;
    logic [3:0]       w_note_sel;
    logic [1:0]       w_octave_sel;
    logic [6:0]       w_led_sel;
    logic [1:0]       w_grant_sel;

    assign w_mode_valid = (mode == c_MODE_FREE) || (mode == c_MODE_AUTO) ||
                          (mode == c_MODE_LEARN);
    assign w_mode_chg   = (mode != r_mode_q);
    assign w_start_rise = start & ~r_start_d;
    // A pending mode change mutes from the very edge that samples it.
    assign w_pass       = (r_state == c_ST_ACTIVE) && !w_mode_chg;

    // Next-state and gap counter: invalid mode wins, then mode change, then the per-state flow.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (!w_mode_valid) begin
            w_state_nxt = c_ST_IDLE;
        end else if (w_mode_chg) begin
            w_state_nxt = c_ST_SWITCH;
            w_cnt_nxt   = c_GAP_LOAD;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    w_state_nxt = c_ST_SWITCH;
                    w_cnt_nxt   = c_GAP_LOAD;
                end
                c_ST_SWITCH: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = c_ST_ACTIVE;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                c_ST_ACTIVE: w_state_nxt = c_ST_ACTIVE;
                default:     w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    // Playback run/pause: a mode change always pauses and beats a simultaneous start edge.
    always_comb begin
        w_play_nxt = r_play_state;
        if (w_mode_chg) begin
            w_play_nxt = 1'b0;
        end else if (w_start_rise && (r_state == c_ST_ACTIVE) && (r_mode_q == c_MODE_AUTO)) begin
            w_play_nxt = ~r_play_state;
        end
    end

    // Source mux; a paused auto source stays granted but silent.
    always_comb begin
        w_note_sel   = '0;
        w_octave_sel = '0;
        w_led_sel    = '0;
        w_grant_sel  = 2'b00;
        if (w_pass) begin
            case (r_mode_q)
                c_MODE_FREE: begin
                    w_note_sel   = note_free;
                    w_octave_sel = octave_free;
                    w_led_sel    = led_free;
                    w_grant_sel  = 2'b01;
                end
                c_MODE_AUTO: begin
                    w_grant_sel = 2'b10;
`ifdef KEY_OVERRIDE_EN
                    if (note_free != 4'd0) begin
                        w_note_sel   = note_free;
                        w_octave_sel = octave_free;
                        w_led_sel    = led_free;
                        w_grant_sel  = 2'b01;
                    end else if (r_play_state) begin
                        w_note_sel   = note_auto;
                        w_octave_sel = octave_auto;
                        w_led_sel    = led_auto;
                    end
`else
                    if (r_play_state) begin
                        w_note_sel   = note_auto;
                        w_octave_sel = octave_auto;
                        w_led_sel    = led_auto;
                    end
`endif
                end
                c_MODE_LEARN: begin
                    w_note_sel   = note_learn;
                    w_octave_sel = octave_learn;
                    w_led_sel    = led_learn;
                    w_grant_sel  = 2'b11;
                end
                default: w_grant_sel = 2'b00;
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_mode_q     <= 3'b000;
            r_start_d    <= 1'b0;
            r_play_state <= 1'b0;
            r_note       <= '0;
            r_octave     <= '0;
            r_led        <= '0;
            r_muting     <= 1'b0;
            r_grant      <= 2'b00;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_mode_q     <= mode;
            r_start_d    <= start;
            r_play_state <= w_play_nxt;
            r_note       <= w_note_sel;
            r_octave     <= w_octave_sel;
            r_led        <= w_led_sel;
            r_muting     <= (w_state_nxt == c_ST_SWITCH);
            r_grant      <= w_grant_sel;
        end
    end

    assign note_out   = r_note;
    assign octave_out = r_octave;
    assign led_out    = r_led;
    assign play_state = r_play_state;
    assign muting     = r_muting;
    assign grant      = r_grant;

endmodule

`default_nettype wire

// File: tb/tb_note_output_arbiter.sv
//============================================================================
// Module      : tb_note_output_arbiter
// Description : Scoreboard bench for note_output_arbiter (GAP_CYCLES=4).
//               Stimulus queues expected outputs tagged with the clock edge
//               after which they must hold; a monitor checks them mid-cycle.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_note_output_arbiter;

    localparam int c_GAP = 4;

    logic       clk;
    logic       reset;
    logic [2:0] mode;
    logic       start;
    logic [3:0] note_free, note_auto, note_learn;
    logic [1:0] octave_free, octave_auto, octave_learn;
    logic [6:0] led_free, led_auto, led_learn;
    logic [3:0] note_out;
    logic [1:0] octave_out;
    logic [6:0] led_out;
    logic       play_state, muting;
    logic [1:0] grant;

    note_output_arbiter #(.GAP_CYCLES(c_GAP), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .mode(mode), .start(start),
        .note_free(note_free), .note_auto(note_auto), .note_learn(note_learn),
        .octave_free(octave_free), .octave_auto(octave_auto), .octave_learn(octave_learn),
        .led_free(led_free), .led_auto(led_auto), .led_learn(led_learn),
        .note_out(note_out), .octave_out(octave_out), .led_out(led_out),
        .play_state(play_state), .muting(muting), .grant(grant)
    );

    typedef struct {
        int          cyc;
        string       name;
        logic [16:0] exp;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected vector: {note, octave, led, play_state, muting, grant}
    function automatic logic [16:0] pk(input logic [3:0] n, input logic [1:0] o,
                                       input logic [6:0] l, input logic p,
                                       input logic m, input logic [1:0] g);
        return {n, o, l, p, m, g};
    endfunction

    task automatic chk(input string name, input int d, input logic [16:0] e);
        exp_t x;
        x.cyc  = cyc + d;
        x.name = name;
        x.exp  = e;
        q.push_back(x);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Monitor: compare every entry due at this edge count; late entries are failures.
    always @(negedge clk) begin
        logic [16:0] act;
        act = {note_out, octave_out, led_out, play_state, muting, grant};
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc <= cyc) begin
                checks = checks + 1;
                if (q[i].cyc < cyc) begin
                    errors = errors + 1;
                    $display("FAIL %s: check missed (due edge %0d, now %0d)", q[i].name, q[i].cyc, cyc);
                end else if (act !== q[i].exp) begin
                    errors = errors + 1;
                    $display("FAIL %s: got %h required %h (edge %0d)", q[i].name, act, q[i].exp, cyc);
                end
                q.delete(i);
            end
        end
    end

    logic [16:0] z;
    logic [16:0] mute;
    logic [16:0] freev;

    initial begin
        z    = pk(4'd0, 2'd0, 7'h00, 1'b0, 1'b0, 2'b00);
        mute = pk(4'd0, 2'd0, 7'h00, 1'b0, 1'b1, 2'b00);
        reset = 1'b0; mode = 3'b100; start = 1'b0;
        note_free = 4'd5; octave_free = 2'd1; led_free = 7'h11;
        note_auto = 4'd9; octave_auto = 2'd3; led_auto = 7'h22;
        note_learn = 4'd7; octave_learn = 2'd2; led_learn = 7'h40;

        tick(2);
        chk("reset_state", 0, z);

        // Release: gap of exactly 4 muted cycles, then free note 5.
        reset = 1'b1;
        chk("rel_mute_first", 1, mute);
        chk("rel_mute_last", c_GAP, mute);
        chk("rel_gap_end", c_GAP + 1, z);
        chk("free_pass", c_GAP + 2, pk(4'd5, 2'd1, 7'h11, 1'b0, 1'b0, 2'b01));
        tick(c_GAP + 2);
        note_free = 4'd3;
        chk("free_hold", 0, pk(4'd5, 2'd1, 7'h11, 1'b0, 1'b0, 2'b01));
        chk("free_latency", 1, pk(4'd3, 2'd1, 7'h11, 1'b0, 1'b0, 2'b01));
        tick(1);

        // Free -> learn.
        mode = 3'b001;
        chk("learn_mute_first", 1, mute);
        chk("learn_mute_last", c_GAP, mute);
        chk("learn_gap_end", c_GAP + 1, z);
        chk("learn_pass", c_GAP + 2, pk(4'd7, 2'd2, 7'h40, 1'b0, 1'b0, 2'b11));
        tick(c_GAP + 2);

        // Learn -> auto, paused.
        mode = 3'b010; note_free = 4'd0;
        chk("auto_mute", 1, mute);
        chk("auto_paused", c_GAP + 2, pk(4'd0, 2'd0, 7'h00, 1'b0, 1'b0, 2'b10));
        tick(c_GAP + 2);

        // First start pulse: play.
        start = 1'b1;
        chk("play_on", 1, pk(4'd0, 2'd0, 7'h00, 1'b1, 1'b0, 2'b10));
        chk("auto_pass", 2, pk(4'd9, 2'd3, 7'h22, 1'b1, 1'b0, 2'b10));
        tick(1); start = 1'b0; tick(2);

        // Second pulse: pause.
        start = 1'b1;
        chk("play_off", 1, pk(4'd9, 2'd3, 7'h22, 1'b0, 1'b0, 2'b10));
        chk("auto_silent", 2, pk(4'd0, 2'd0, 7'h00, 1'b0, 1'b0, 2'b10));
        tick(1); start = 1'b0; tick(1);

        // Held start toggles once only.
        start = 1'b1;
        chk("hold_toggle", 1, pk(4'd0, 2'd0, 7'h00, 1'b1, 1'b0, 2'b10));
        chk("hold_once", 10, pk(4'd9, 2'd3, 7'h22, 1'b1, 1'b0, 2'b10));
        tick(10); start = 1'b0; tick(1);

        // Key override.
        note_auto = 4'd4;
        chk("auto_note4", 1, pk(4'd4, 2'd3, 7'h22, 1'b1, 1'b0, 2'b10));
        tick(1);
        note_free = 4'd6;
`ifdef KEY_OVERRIDE_EN
        chk("override_on", 1, pk(4'd6, 2'd1, 7'h11, 1'b1, 1'b0, 2'b01));
`else
        chk("override_off", 1, pk(4'd4, 2'd3, 7'h22, 1'b1, 1'b0, 2'b10));
`endif
        tick(1);
        note_free = 4'd0;
        chk("override_release", 1, pk(4'd4, 2'd3, 7'h22, 1'b1, 1'b0, 2'b10));
        tick(1);

        // Start edge together with mode change: mode change wins.
        start = 1'b1; mode = 3'b100;
        chk("chg_beats_start", 1, mute);
        tick(1); start = 1'b0; tick(1);
        start = 1'b1;
        chk("start_in_switch", 1, mute);
        tick(1); start = 1'b0;
        chk("switch_gap_end", 2, z);
        chk("free_after_auto", 3, pk(4'd0, 2'd1, 7'h11, 1'b0, 1'b0, 2'b01));
        tick(3);

        // Invalid mode -> IDLE, then restart of the gap mid-SWITCH.
        mode = 3'b011;
        chk("invalid_idle", 1, z);
        tick(3);
        chk("invalid_stay", 0, z);
        mode = 3'b010;
        chk("valid_again_mute", 1, mute);
        tick(2);
        mode = 3'b100;
        chk("restart_mute", 1, mute);
        chk("restart_full_gap", c_GAP, mute);
        chk("restart_gap_end", c_GAP + 1, z);
        chk("restart_pass", c_GAP + 2, pk(4'd0, 2'd1, 7'h11, 1'b0, 1'b0, 2'b01));
        tick(c_GAP + 2);

        // Asynchronous reset mid-operation clears outputs before the next edge.
        freev = pk(4'd0, 2'd1, 7'h11, 1'b0, 1'b0, 2'b01);
        chk("pre_reset", 0, freev);
        tick(1);
        reset = 1'b0;
        chk("async_reset", 0, z);
        tick(2);

        for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
        while (q.size() > 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s: never checked (due edge %0d)", q[0].name, q[0].cyc);
            void'(q.pop_front());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
